serial_input_buffer: RTL and testbench
======================================

# serial_input_buffer

Parametrised, multi-lane successor to the single-lane input shift register. It deserialises an externally clocked bit stream on `numLanes` parallel data lanes into a shadow register, all in the `CLOCK_50` domain. A completed frame is held until `pushBuffer` transfers it in one cycle to the double-buffered `dataOut` that feeds the first neural-network layer. It adds frame framing, abort, overrun and short-push detection.

## Interface
- `numInputs`, 784, number of input words; must be divisible by `numLanes`
- `dataWidth`, 16, bits per word
- `numLanes`, 1, parallel serial data lanes; each lane carries `wpl = numInputs/numLanes` words
- `CLOCK_50`  in  1  sole clock; all logic on its rising edge
- `resetN`  in  1  synchronous, active-low reset
- `serialClock`  in  1  asynchronous bit clock, sampled; bits are taken on its rising edge
- `serialFrame`  in  1  asynchronous frame enable, high for the duration of a frame
- `serialData`  in  `numLanes`  asynchronous data; bit L is lane L
- `pushBuffer`  in  1  synchronous strobe that copies a complete frame to `dataOut`
- `clearErrors`  in  1  synchronous strobe that clears the sticky flags
- `dataOut`  out  `numInputs*dataWidth`  word i is at `[i*dataWidth +: dataWidth]`
- `dataValid`  out  1  one-cycle pulse, high in the cycle `dataOut` first shows a new frame
- `frameReady`  out  1  level, high while a complete frame waits in the shadow register
- `overrun`  out  1  sticky: a bit edge arrived while in FULL
- `shortPush`  out  1  sticky: `pushBuffer` arrived while not in FULL
- `bitCount`  out  `$clog2(wpl*dataWidth+1)`  bits received per lane in the current frame

## Operation
- Synchronisation:
  - `serialClock`, `serialFrame` and `serialData` all pass through one 2-FF synchroniser plus one history register.
  - `bitEdge` = synchronised clock high AND history low.
- Capture:
  - On `bitEdge` with synchronised frame high, each lane's shift register (`wpl*dataWidth` bits) shifts left.
  - The lane's synchronised data bit enters at the LSB.
  - After a full frame, the first bit received on lane L sits at `dataOut` bit `(L+1)*wpl*dataWidth-1`. The stream is the lane slice, MSB first, with the highest word first.
- FSM (enum in package):
  - IDLE → SHIFT on `bitEdge` with frame high; that bit is captured and `bitCount` becomes 1.
  - SHIFT: each `bitEdge` increments `bitCount`.
    - When it reaches `wpl*dataWidth`, the state goes to FULL.
    - If the frame goes low before that, the state goes to IDLE with `bitCount` = 0. The shadow register becomes don't-care and `dataOut` is untouched.
  - FULL: `frameReady` = 1 and the frame-enable level is ignored.
    - A `bitEdge` here sets `overrun` and its data is discarded.
    - `pushBuffer` copies the shadow register to `dataOut`, pulses `dataValid` next cycle, clears `bitCount` and goes to IDLE.
- `pushBuffer` outside FULL: ignored and sets `shortPush`. A held `pushBuffer` acts only in its first FULL cycle; later cycles set `shortPush`.
- `clearErrors`: clears both sticky flags. If it coincides with a setting event, the set wins.
- Edges while frame low in IDLE are ignored.

## Timing
- Reset (`resetN` low at a clock edge):
  - State IDLE, all synchroniser/history flops 0.
  - `dataOut`, `dataValid`, `frameReady`, `overrun`, `shortPush` and `bitCount` all 0; shadow register cleared.
  - Reset mid-frame discards the frame.
- Capture latency: a `serialClock` rise first sampled at cycle n updates the shadow register and `bitCount` at the edge ending cycle n+2 (3 `CLOCK_50` edges).
- Input requirements:
  - `serialClock` high ≥2 and low ≥2 `CLOCK_50` periods.
  - `serialData` stable from 3 periods before to 1 after each rise.
  - `serialFrame` high ≥3 periods before the first rise.
- `frameReady` rises in the cycle after the last bit's capture edge.
- Push latency: `pushBuffer` high in cycle m (FULL) gives:
  - `dataOut` valid and `dataValid` = 1 in cycle m+1;
  - `frameReady` = 0 in m+1.
- Simultaneous push and `bitEdge` in FULL:
  - The push is accepted and `overrun` is not set.
  - The edge is captured as bit 1 of the next frame if frame is high: state SHIFT, `bitCount` = 1 in m+1.
- `dataOut` changes only on an accepted push, so downstream may read it at any time.

## Structure
- Package `nn_input_pkg`: state enum (`IDLE`, `SHIFT`, `FULL`) and `localparam` helpers `WPL` and `LANE_BITS`, shared with future layer-input blocks.
- Sub-module `serial_edge_sync #(width)`: 2-FF synchroniser plus history register with a per-bit rise output. Instantiated once with width `numLanes+2`.

## Test plan
- Config numInputs=4, dataWidth=4, numLanes=2: stream lane0 = 0xA5, lane1 = 0x3C, then push → `dataOut` = 0x3CA5, `dataValid` pulses once, `frameReady` 0 → 1 → 0.
- Abort: 5 bits then frame low, then a full frame 0x12/0x34 → `dataOut` = 0x3412 with no residue from the abort; `bitCount` reset to 0 at abort.
- Overrun: full frame plus 1 extra edge → `overrun` = 1 and data unchanged; `clearErrors` → 0.
- Short push: push at `bitCount` = 3 → `shortPush` = 1, `dataOut` unchanged, capture continues.
- Push coincident with first bit of next frame → frame accepted, `bitCount` = 1, `overrun` = 0.
- Default config with random 12544-bit frame and reset asserted mid-frame → all outputs 0 one cycle later; a subsequent frame is received bit-exact.

Source files
------------

// File: rtl/nn_input_pkg.sv
// Shared definitions for neural-network layer-input blocks.
// Holds the capture FSM state encoding and lane-sizing helpers.
package nn_input_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Default first-layer geometry (784 x 16-bit words on one lane).
  localparam int unsigned DEF_NUM_INPUTS = 784;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_NUM_LANES  = 1;

  // Words per lane and bits per lane for the default geometry.
  localparam int unsigned WPL       = DEF_NUM_INPUTS / DEF_NUM_LANES;
  localparam int unsigned LANE_BITS = WPL * DEF_DATA_WIDTH;

  // Words carried by each lane for an arbitrary geometry.
  function automatic int unsigned wpl_of(input int unsigned num_inputs,
                                         input int unsigned num_lanes);
    return num_inputs / num_lanes;
  endfunction

  // Shift-register length of each lane for an arbitrary geometry.
  function automatic int unsigned lane_bits_of(input int unsigned num_inputs,
                                               input int unsigned data_width,
                                               input int unsigned num_lanes);
    return wpl_of(num_inputs, num_lanes) * data_width;
  endfunction

endpackage

// File: rtl/serial_edge_sync.sv
// Two-flop synchroniser plus history register for a bundle of async inputs.
// Ports:
//   clk     - sampling clock
//   reset_n - synchronous active-low reset
//   raw     - asynchronous inputs
//   level   - synchronised levels (registered)
//   rise_c  - per-bit rising edge of the synchronised level (combinational)
module serial_edge_sync #(
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [width-1:0] raw,
  output logic [width-1:0] level,
  output logic [width-1:0] rise_c
);

  logic [width-1:0] meta;
  logic [width-1:0] hist;

  // Metastability chain followed by one cycle of history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta  <= '0;
      level <= '0;
      hist  <= '0;
    end else begin
      meta  <= raw;
      level <= meta;
      hist  <= level;
    end
  end

  assign rise_c = level & ~hist;

endmodule

// File: rtl/serial_input_buffer.sv
// Multi-lane serial deserialiser with a shadow register and a double-buffered
// parallel output feeding the first network layer.
// Ports:
//   CLOCK_50    - sole clock
//   resetN      - synchronous active-low reset
//   serialClock - async bit clock, bits taken on its rise
//   serialFrame - async frame enable
//   serialData  - async data, one bit per lane
//   pushBuffer  - copy a complete frame to dataOut
//   clearErrors - clear the sticky flags
//   dataOut     - parallel frame, word i at [i*dataWidth +: dataWidth]
//   dataValid   - one-cycle pulse when dataOut shows a new frame
//   frameReady  - a complete frame waits in the shadow register
//   overrun     - sticky: bit edge arrived while full
//   shortPush   - sticky: push arrived while not full
//   bitCount    - bits received per lane in the current frame
module serial_input_buffer
  import nn_input_pkg::*;
#(
  parameter int unsigned numInputs = 784,
  parameter int unsigned dataWidth = 16,
  parameter int unsigned numLanes  = 1
) (
  input  logic                                          CLOCK_50,
  input  logic                                          resetN,
  input  logic                                          serialClock,
  input  logic                                          serialFrame,
  input  logic [numLanes-1:0]                           serialData,
  input  logic                                          pushBuffer,
  input  logic                                          clearErrors,
  output logic [numInputs*dataWidth-1:0]                dataOut,
  output logic                                          dataValid,
  output logic                                          frameReady,
  output logic                                          overrun,
  output logic                                          shortPush,
  output logic [$clog2(numInputs/numLanes*dataWidth+1)-1:0] bitCount
);

  localparam int unsigned lane_bits  = lane_bits_of(numInputs, dataWidth, numLanes);
  localparam int unsigned frame_bits = numInputs * dataWidth;
  localparam int unsigned cnt_w      = $clog2(lane_bits + 1);
  localparam int unsigned sync_w     = numLanes + 2;
  // A one-bit lane fills on its first bit.
  localparam state_t first_state = (lane_bits == 1) ? FULL : SHIFT;

  logic [sync_w-1:0]     sync_level;
  logic [sync_w-1:0]     sync_rise;
  logic                  bit_edge;
  logic                  frame_lvl;
  logic [numLanes-1:0]   lane_data;
  logic                  sync_unused;

  state_t                state;
  state_t                state_d;
  logic [cnt_w-1:0]      count_d;
  logic                  capture;
  logic                  push_ok;
  logic                  set_ovr;
  logic                  set_short;
  logic [frame_bits-1:0] shadow;
  logic [frame_bits-1:0] shadow_next;

  // Bit 0 clock, bit 1 frame, upper bits lane data.
  serial_edge_sync #(.width(sync_w)) u_sync (
    .clk     (CLOCK_50),
    .reset_n (resetN),
    .raw     ({serialData, serialFrame, serialClock}),
    .level   (sync_level),
    .rise_c  (sync_rise)
  );

  assign bit_edge    = sync_rise[0];
  assign frame_lvl   = sync_level[1];
  assign lane_data   = sync_level[sync_w-1:2];
  assign sync_unused = ^{sync_rise[sync_w-1:1], sync_level[0]};

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!resetN) state <= IDLE;
    else         state <= state_d;
  end

  // Next state, bit counter and datapath strobes.
  always_comb begin
    state_d   = state;
    count_d   = bitCount;
    capture   = 1'b0;
    push_ok   = 1'b0;
    set_ovr   = 1'b0;
    set_short = pushBuffer && (state != FULL);
    unique case (state)
      IDLE: begin
        if (bit_edge && frame_lvl) begin
          capture = 1'b1;
          count_d = cnt_w'(1);
          state_d = first_state;
        end
      end
      SHIFT: begin
        if (!frame_lvl) begin
          count_d = '0;
          state_d = IDLE;
        end else if (bit_edge) begin
          capture = 1'b1;
          count_d = bitCount + cnt_w'(1);
          if (count_d == cnt_w'(lane_bits)) state_d = FULL;
        end
      end
      FULL: begin
        if (pushBuffer) begin
          push_ok = 1'b1;
          count_d = '0;
          state_d = IDLE;
          // An edge coinciding with the push starts the next frame.
          if (bit_edge && frame_lvl) begin
            capture = 1'b1;
            count_d = cnt_w'(1);
            state_d = first_state;
          end
        end else if (bit_edge) begin
          set_ovr = 1'b1;
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Every lane shifts left with its new bit entering at the lane LSB.
  always_comb begin
    shadow_next = shadow;
    for (int l = 0; l < int'(numLanes); l++) begin
      shadow_next[l*lane_bits +: lane_bits] =
        (shadow[l*lane_bits +: lane_bits] << 1) | lane_bits'(lane_data[l]);
    end
  end

  // Registered outputs and shadow register.
  always_ff @(posedge CLOCK_50) begin
    if (!resetN) begin
      shadow     <= '0;
      dataOut    <= '0;
      dataValid  <= 1'b0;
      frameReady <= 1'b0;
      overrun    <= 1'b0;
      shortPush  <= 1'b0;
      bitCount   <= '0;
    end else begin
      bitCount   <= count_d;
      dataValid  <= push_ok;
      frameReady <= (state_d == FULL);
      // Setting events take priority over a simultaneous clear.
      overrun    <= set_ovr   | (overrun   & ~clearErrors);
      shortPush  <= set_short | (shortPush & ~clearErrors);
      if (push_ok) dataOut <= shadow;
      if (capture) shadow  <= shadow_next;
    end
  end

endmodule

// File: tb/tb_serial_input_buffer.sv
// Self-checking bench for serial_input_buffer in a 4-word, 4-bit, 2-lane setup.
module tb_serial_input_buffer;

  localparam int unsigned NI = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned NL = 2;
  localparam int unsigned LB = NI / NL * DW;
  localparam int unsigned FB = NI * DW;
  localparam int unsigned CW = $clog2(LB + 1);

  logic          clk    = 1'b0;
  logic          resetN = 1'b0;
  logic          sclk   = 1'b0;
  logic          sframe = 1'b0;
  logic [NL-1:0] sdata  = '0;
  logic          push   = 1'b0;
  logic          clr    = 1'b0;
  logic [FB-1:0] dout;
  logic          dvalid;
  logic          fready;
  logic          ovr;
  logic          spush;
  logic [CW-1:0] bcnt;

  int checks = 0;
  int errors = 0;
  logic [FB-1:0] exp_out = '0;
  logic          spush_exp = 1'b0;
  logic [FB-1:0] f;
  logic [FB-1:0] f2;

  serial_input_buffer #(.numInputs(NI), .dataWidth(DW), .numLanes(NL)) dut (
    .CLOCK_50    (clk),
    .resetN      (resetN),
    .serialClock (sclk),
    .serialFrame (sframe),
    .serialData  (sdata),
    .pushBuffer  (push),
    .clearErrors (clr),
    .dataOut     (dout),
    .dataValid   (dvalid),
    .frameReady  (fready),
    .overrun     (ovr),
    .shortPush   (spush),
    .bitCount    (bcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit k of each lane's stream: lane slice sent MSB first.
  function automatic logic [NL-1:0] lane_bits_at(input logic [FB-1:0] fr, input int k);
    logic [NL-1:0] d;
    for (int l = 0; l < int'(NL); l++) d[l] = fr[(l+1)*int'(LB)-1-k];
    return d;
  endfunction

  // One serial bit: data settles, clock high 2 periods, low until capture is done.
  task automatic send_bit(input logic [NL-1:0] d, input bit with_push);
    sdata = d;
    tick(3);
    sclk = 1'b1;
    tick(2);
    sclk = 1'b0;
    if (with_push) begin
      push = 1'b1;
      tick(1);
      push = 1'b0;
      check("cpush_valid", 64'(dvalid), 64'd1);
      check("cpush_count", 64'(bcnt), 64'd1);
      check("cpush_overrun", 64'(ovr), 64'd0);
      check("cpush_ready", 64'(fready), 64'd0);
      check("cpush_out", 64'(dout), 64'(exp_out));
      tick(1);
    end else begin
      tick(2);
    end
  endtask

  task automatic send_range(input logic [FB-1:0] fr, input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      send_bit(lane_bits_at(fr, k), 1'b0);
      check("bitcount", 64'(bcnt), 64'(k + 1));
    end
  endtask

  task automatic do_push();
    push = 1'b1;
    tick(1);
    push = 1'b0;
    check("push_valid", 64'(dvalid), 64'd1);
    check("push_ready", 64'(fready), 64'd0);
    check("push_out", 64'(dout), 64'(exp_out));
    check("push_count", 64'(bcnt), 64'd0);
    tick(1);
    check("valid_once", 64'(dvalid), 64'd0);
  endtask

  task automatic start_frame();
    sframe = 1'b1;
    tick(3);
  endtask

  task automatic end_frame();
    sframe = 1'b0;
    tick(4);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out"}, 64'(dout), 64'd0);
    check({tag, "_valid"}, 64'(dvalid), 64'd0);
    check({tag, "_ready"}, 64'(fready), 64'd0);
    check({tag, "_overrun"}, 64'(ovr), 64'd0);
    check({tag, "_short"}, 64'(spush), 64'd0);
    check({tag, "_count"}, 64'(bcnt), 64'd0);
  endtask

  initial begin
    int k;
    int hold;

    // Reset state.
    tick(3);
    check_zero("reset");
    resetN = 1'b1;
    tick(2);

    // Edges with frame low are ignored.
    send_bit(2'b11, 1'b0);
    send_bit(2'b10, 1'b0);
    check("idle_count", 64'(bcnt), 64'd0);
    check("idle_ready", 64'(fready), 64'd0);

    // Basic frame 0x3CA5.
    f = 16'h3CA5;
    start_frame();
    check("pre_ready", 64'(fready), 64'd0);
    send_range(f, 0, int'(LB));
    check("full_ready", 64'(fready), 64'd1);
    check("full_out_held", 64'(dout), 64'd0);
    end_frame();
    check("full_ignores_frame", 64'(fready), 64'd1);
    exp_out = f;
    do_push();

    // Abort after 5 bits, then 0x3412.
    start_frame();
    send_range(16'hFFFF, 0, 5);
    end_frame();
    check("abort_count", 64'(bcnt), 64'd0);
    check("abort_ready", 64'(fready), 64'd0);
    check("abort_out", 64'(dout), 64'(exp_out));
    f = 16'h3412;
    start_frame();
    send_range(f, 0, int'(LB));
    end_frame();
    exp_out = f;
    do_push();

    // Overrun: one extra edge in FULL is discarded.
    f = FB'($urandom);
    start_frame();
    send_range(f, 0, int'(LB));
    send_bit(2'b11, 1'b0);
    check("ovr_set", 64'(ovr), 64'd1);
    check("ovr_out", 64'(dout), 64'(exp_out));
    check("ovr_count", 64'(bcnt), 64'(LB));
    check("ovr_ready", 64'(fready), 64'd1);
    end_frame();
    exp_out = f;
    do_push();
    check("ovr_sticky", 64'(ovr), 64'd1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("ovr_clear", 64'(ovr), 64'd0);

    // Push and clear together: the set wins.
    push = 1'b1;
    clr  = 1'b1;
    tick(1);
    push = 1'b0;
    clr  = 1'b0;
    check("set_wins", 64'(spush), 64'd1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("short_clear", 64'(spush), 64'd0);

    // Short push at bitCount 3; capture continues.
    f = FB'($urandom);
    start_frame();
    send_range(f, 0, 3);
    push = 1'b1;
    tick(1);
    push = 1'b0;
    check("short_set", 64'(spush), 64'd1);
    check("short_valid", 64'(dvalid), 64'd0);
    check("short_out", 64'(dout), 64'(exp_out));
    send_range(f, 3, int'(LB));
    check("short_ready", 64'(fready), 64'd1);
    exp_out = f;
    do_push();
    check("short_sticky", 64'(spush), 64'd1);
    end_frame();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;

    // Push coincident with the first bit of the next frame.
    f  = FB'($urandom);
    f2 = FB'($urandom);
    start_frame();
    send_range(f, 0, int'(LB));
    exp_out = f;
    send_bit(lane_bits_at(f2, 0), 1'b1);
    send_range(f2, 1, int'(LB));
    check("next_ready", 64'(fready), 64'd1);
    check("next_overrun", 64'(ovr), 64'd0);
    end_frame();
    exp_out = f2;
    do_push();

    // Randomised frames, aborts and held pushes.
    spush_exp = 1'b0;
    for (int it = 0; it < 30; it++) begin
      f = FB'($urandom);
      start_frame();
      if ($urandom_range(0, 3) == 0) begin
        k = int'($urandom_range(1, LB - 1));
        send_range(f, 0, k);
        end_frame();
        check("rnd_abort_count", 64'(bcnt), 64'd0);
        check("rnd_abort_out", 64'(dout), 64'(exp_out));
      end else begin
        send_range(f, 0, int'(LB));
        check("rnd_ready", 64'(fready), 64'd1);
        end_frame();
        hold = int'($urandom_range(1, 2));
        exp_out = f;
        push = 1'b1;
        tick(1);
        check("rnd_out", 64'(dout), 64'(exp_out));
        check("rnd_valid", 64'(dvalid), 64'd1);
        check("rnd_ready_low", 64'(fready), 64'd0);
        if (hold == 2) begin
          tick(1);
          spush_exp = 1'b1;
          check("rnd_valid_held", 64'(dvalid), 64'd0);
        end
        push = 1'b0;
        tick(1);
        check("rnd_valid_end", 64'(dvalid), 64'd0);
        check("rnd_short", 64'(spush), 64'(spush_exp));
        check("rnd_overrun", 64'(ovr), 64'd0);
        if ($urandom_range(0, 1) == 1) begin
          clr = 1'b1;
          tick(1);
          clr = 1'b0;
          spush_exp = 1'b0;
          check("rnd_clear", 64'(spush), 64'd0);
        end
      end
    end

    // Reset mid-frame with sticky flag and data set, then a clean frame.
    f = FB'($urandom);
    start_frame();
    send_range(f, 0, 3);
    push = 1'b1;
    tick(1);
    push = 1'b0;
    resetN = 1'b0;
    tick(1);
    check_zero("midreset");
    resetN = 1'b1;
    end_frame();
    exp_out = '0;
    f = FB'($urandom);
    start_frame();
    send_range(f, 0, int'(LB));
    end_frame();
    exp_out = f;
    do_push();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
